// File: rtl/cdp_pkg.sv
// cdp_pkg: word format, tag codes and FSM encodings shared by the CDP packet transmitter.
package cdp_pkg;
    localparam int CDP_W   = 139;
    localparam int TAG_HI  = 138;
    localparam int TAG_LO  = 136;
    localparam int INV_HI  = 135;
    localparam int INV_LO  = 132;
    localparam int PORT_HI = 131;
    localparam int PORT_LO = 128;
    localparam int PAY_HI  = 127;
    localparam int PAY_LO  = 0;
    localparam logic [2:0] TAG_HEAD   = 3'b101;
    localparam logic [2:0] TAG_MID    = 3'b100;
    localparam logic [2:0] TAG_TAIL   = 3'b110;
    localparam logic [2:0] TAG_SINGLE = 3'b111;
    typedef enum logic [1:0] {IDLE, SEND, GAP} out_st_t;
    typedef enum logic [1:0] {WAIT_HEAD, IN_PKT, DISCARD} in_st_t;
    function automatic logic [2:0] tag_of(input logic [CDP_W-1:0] w);
        return w[TAG_HI:TAG_LO];
    endfunction
    function automatic logic is_end(input logic [2:0] t);
        return t == TAG_TAIL || t == TAG_SINGLE;
    endfunction
endpackage

// File: rtl/cdp_pkt_buf.sv
// cdp_pkt_buf: packet RAM with speculative write pointer; commit publishes a packet, rollback drops it.
module cdp_pkt_buf import cdp_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CDP_W-1:0] wdata,
    input  logic             commit,
    input  logic             rollback,
    input  logic             rd,
    output logic [CDP_W-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [CDP_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr, base, next_wr;
    // a rollback and a write in the same cycle restart the packet at commit_ptr
    assign base    = rollback ? commit_ptr : wr_ptr;
    assign next_wr = base + {{AW{1'b0}}, we};
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = commit_ptr == rd_ptr;

    always_ff @(posedge clk)
        if (we) mem[base[AW-1:0]] <= wdata;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rdata      <= '0;
        end else begin
            wr_ptr <= next_wr;
            if (commit) commit_ptr <= next_wr;
            if (rd) begin
                rdata  <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
endmodule

// File: rtl/cdp_pkt_tx.sv
// cdp_pkt_tx: store-and-forward packet transmitter toward UM, dropping malformed/oversized packets.
// Define CDP_TX_STATS_EN to build the transmitted-packet counter tx_pkt_cnt.
module cdp_pkt_tx import cdp_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [CDP_W-1:0] in_data,
    output logic             in_ready,
    input  logic             um2cdp_tx_enable,
    output logic             cdp2um_data_valid,
    output logic [CDP_W-1:0] cdp2um_data,
    output logic [AW:0]      pkt_pending,
    output logic [15:0]      err_cnt,
    output logic [31:0]      tx_pkt_cnt
);
    in_st_t     ist, ist_nx;
    out_st_t    ost;
    logic       up, full, empty, acc, ovf, we, commit, rollback, err_inc;
    logic       start, last, done, rd, in_end;
    logic [2:0] tag;

    cdp_pkt_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk(clk), .reset(reset), .we(we), .wdata(in_data), .commit(commit),
        .rollback(rollback), .rd(rd), .rdata(cdp2um_data), .full(full), .empty(empty)
    );

    assign in_ready = up && (ist == DISCARD || !(full && pkt_pending != '0));
    assign acc      = in_valid && in_ready;
    assign tag      = tag_of(in_data);
    assign in_end   = is_end(tag);
    // an unfinished packet that fills the whole buffer can never complete
    assign ovf      = ist == IN_PKT && full && pkt_pending == '0;

    always_comb begin
        we       = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        err_inc  = 1'b0;
        ist_nx   = ist;
        if (ovf) begin
            rollback = 1'b1;
            err_inc  = 1'b1;
            ist_nx   = acc && in_end ? WAIT_HEAD : DISCARD;
        end else if (acc) begin
            case (ist)
                WAIT_HEAD: begin
                    we      = tag == TAG_HEAD || tag == TAG_SINGLE;
                    commit  = tag == TAG_SINGLE;
                    err_inc = !we;
                    ist_nx  = tag == TAG_HEAD ? IN_PKT : WAIT_HEAD;
                end
                IN_PKT: begin
                    we       = 1'b1;
                    rollback = tag == TAG_HEAD || tag == TAG_SINGLE;
                    err_inc  = rollback;
                    commit   = in_end;
                    ist_nx   = in_end ? WAIT_HEAD : IN_PKT;
                end
                default: ist_nx = in_end ? WAIT_HEAD : DISCARD;
            endcase
        end
    end

    assign start = ost == IDLE && pkt_pending != '0 && !empty && um2cdp_tx_enable;
    assign last  = is_end(tag_of(cdp2um_data));
    assign done  = ost == SEND && last;
    assign rd    = start || (ost == SEND && !last);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ist         <= WAIT_HEAD;
            up          <= 1'b0;
            err_cnt     <= '0;
            pkt_pending <= '0;
        end else begin
            ist         <= ist_nx;
            up          <= 1'b1;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            pkt_pending <= pkt_pending + (AW+1)'(commit) - (AW+1)'(done);
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ost               <= IDLE;
            cdp2um_data_valid <= 1'b0;
        end else begin
            case (ost)
                IDLE: if (start) begin
                    ost               <= SEND;
                    cdp2um_data_valid <= 1'b1;
                end
                SEND: if (last) begin
                    ost               <= GAP;
                    cdp2um_data_valid <= 1'b0;
                end
                default: ost <= IDLE;
            endcase
        end

`ifdef CDP_TX_STATS_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) tx_pkt_cnt <= '0;
        else if (done) tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
`else
    assign tx_pkt_cnt = '0;
`endif
endmodule

// File: doc/cdp_pkt_tx.md
Name: cdp_pkt_tx

Overview:
- CDP-side transmitter that drives the 139-bit cdp2um packet stream into the UM pipeline.
- Buffers complete packets store-and-forward from a host-side word interface.
- Starts a packet only when UM grants it through um2cdp_tx_enable.
- Drops malformed or oversized packets atomically, using commit/rollback of the write pointer.

Parameters:
- DEPTH, 256, buffer depth in 139-bit words; power of two, minimum 4.
- AW, 8, log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host word valid.
- in_data  in  139  host word, same format as cdp2um_data.
- in_ready  out  1  buffer accepts in_data this cycle.
- um2cdp_tx_enable  in  1  UM grant; high means UM can take a new packet.
- cdp2um_data_valid  out  1  word valid toward UM.
- cdp2um_data  out  139  word toward UM.
- pkt_pending  out  AW+1  number of complete packets buffered.
- err_cnt  out  16  count of dropped packets, saturating.
- tx_pkt_cnt  out  32  count of transmitted packets (see Optional Feature).

Behaviour:
- Word format:
  - [138:136] tag: 3'b101 head, 3'b100 middle, 3'b110 tail, 3'b111 single-word packet.
  - [135:132] invalid-byte count of the word.
  - [131:128] port.
  - [127:0] payload.
- Reset values: in_ready=0, cdp2um_data_valid=0, cdp2um_data=0, pkt_pending=0, err_cnt=0, tx_pkt_cnt=0. Pointers clear; the input FSM enters WAIT_HEAD.
- in_ready is 1 from the first cycle after reset, except when the buffer is full and pkt_pending>0.
- Input FSM:
  - WAIT_HEAD:
    - head → write the word, go to IN_PKT.
    - single → write the word, commit.
    - middle or tail → discard the word, err_cnt+1.
  - IN_PKT:
    - middle → write the word.
    - tail → write the word, commit.
    - head → roll wr_ptr back to commit_ptr, err_cnt+1, then take the new head as the start of a new packet.
    - single → roll back, err_cnt+1, write and commit the single.
  - Commit: commit_ptr <= wr_ptr+1 and pkt_pending+1, in the same cycle as the final write.
  - Overflow: buffer full while in IN_PKT with pkt_pending==0 → roll back, err_cnt+1, go to DISCARD.
  - DISCARD: keep in_ready=1 and drop every word; tail or single returns the FSM to WAIT_HEAD.
  - Buffer full with pkt_pending>0: in_ready=0 and the state is held.
- Output FSM:
  - IDLE:
    - Leave when pkt_pending>0 and um2cdp_tx_enable==1 are both true in the same cycle.
    - Then read the first word and go to SEND.
    - The first word appears on cdp2um_data with valid=1 in the next cycle, giving 1-cycle latency.
  - SEND:
    - Output one word per cycle, back to back, with no bubbles.
    - um2cdp_tx_enable is ignored inside a packet; UM lowers it after seeing valid.
    - The cycle that drives the tail or single word issues pkt_pending-1, and the FSM goes to GAP.
  - GAP: valid=0 for exactly one cycle, then IDLE.
    - UM re-raises enable only after it sees valid low, so the gap is at least 1 cycle. It is 2 cycles in practice.
  - cdp2um_data holds its last value while valid=0.
- A commit and a transmit completing in the same cycle leave pkt_pending unchanged.
- Pointers are AW bits and wrap modulo DEPTH. Full and empty are distinguished with an extra MSB.
- err_cnt saturates at 16'hFFFF.
- reset asserted mid-packet aborts everything at once: outputs go to their reset values and all buffered data is lost.

Optional Feature:
- Macro CDP_TX_STATS_EN.
- Defined: tx_pkt_cnt increments in the GAP entry cycle and wraps modulo 2^32.
- Undefined: tx_pkt_cnt is driven constant 0 and no counter logic is built.

Decomposition:
- Package cdp_pkg:
  - constants TAG_HEAD/MID/TAIL/SINGLE and CDP_W=139;
  - field-slice localparams;
  - output FSM state encodings IDLE/SEND/GAP;
  - input FSM state encodings WAIT_HEAD/IN_PKT/DISCARD.
- One sub-module, cdp_pkt_buf: dual-port RAM, wr_ptr, commit_ptr, rd_ptr, full/empty, and commit/rollback inputs.
- Both FSMs and the counters stay in cdp_pkt_tx.

Test Plan:
- 3-word packet (101,100,110) written with enable=1:
  - valid is high for 3 consecutive cycles;
  - words are bit-identical;
  - then 1 cycle valid=0;
  - pkt_pending goes 1→0.
- Two single-word packets (111) with enable toggled the way UM does it (low 1 cycle after valid):
  - second packet starts only after enable re-rises;
  - at least 2 cycles of valid=0 between packets.
- Head, middle, then a new head before any tail:
  - err_cnt=1;
  - only the second packet is transmitted;
  - the first packet's words never appear.
- A tail with no preceding head: discarded, err_cnt=1, nothing transmitted, pkt_pending=0.
- DEPTH=4 and a 6-word packet:
  - rollback, err_cnt=1, in_ready stays 1, the remainder is discarded;
  - a following 2-word packet transmits correctly.
- Reset pulsed mid-SEND of a 5-word packet: valid=0 next cycle, pkt_pending=0, and no stale words after reset.
